video_bringup_ctrl: RTL and testbench
=====================================

Name: video_bringup_ctrl

Overview:
- Power-up and recovery sequencer for the HDMI picture path.
- Waits for stable PLL lock, then releases the DVI transmitter reset, then the sync/timing generator reset.
- Blanks a programmable number of frames, then enables picture output.
- On PLL lock loss or a vsync timeout it tears the path down, counts the fault, and re-sequences automatically.

Parameters:
- LOCK_WAIT, 16'd10000: pix_clk cycles lock must stay stable before bring-up (≥2).
- TX_LEAD, 8'd16: cycles tx_rstn leads timing_rstn (≥1).
- BLANK_FRAMES, 4'd2: active vsync edges counted in BLANK before pic_en (≥1).
- VS_TIMEOUT, 24'd4000000: max cycles between vsync edges in TIMING_UP/BLANK/RUN.
- FAULT_HOLD, 8'd32: cycles spent in FAULT before retry (≥1).
- VS_POL, 1'b1: active level of vs_in.

Ports:
- pix_clk, input, 1: pixel clock; sole clock.
- rstn, input, 1: synchronous active-low reset, sampled on pix_clk rising edge.
- pll_locked, input, 1: asynchronous lock (lock1 & lock2); 2-FF synchronised internally.
- vs_in, input, 1: vsync from the timing generator, pix_clk domain.
- tx_rstn, output, 1: active-low reset for the DVI transmitter.
- timing_rstn, output, 1: active-low reset for the sync generator and video source.
- pic_en, output, 1: 1 = pass picture, 0 = force black.
- state_o, output, 3: current state encoding.
- fault_cnt, output, 8: saturating count of faults taken.

Behaviour:
- Reset (rstn=0 at edge):
  - state = WAIT_LOCK; sync flops = 0; vs_d = ~VS_POL; all counters = 0.
  - tx_rstn = 0, timing_rstn = 0, pic_en = 0, fault_cnt = 0.
  - Reset mid-sequence behaves identically.
- States: WAIT_LOCK = 0, SETTLE = 1, TX_UP = 2, TIMING_UP = 3, BLANK = 4, RUN = 5, FAULT = 6. Code 7 is unused; it returns to WAIT_LOCK.
- Outputs are Moore decodes of the state register, with no added latency:
  - tx_rstn = 1 in TX_UP..RUN.
  - timing_rstn = 1 in TIMING_UP..RUN.
  - pic_en = 1 only in RUN.
- lk = second synchroniser flop. pll_locked rising before edge N gives lk=1 after edge N+1; the FSM acts at edge N+2.
- vs_edge = (vs_in == VS_POL) && (vs_d != VS_POL); vs_d registers vs_in every cycle.
- WAIT_LOCK: if lk=1, go to SETTLE with cnt = 0.
- SETTLE:
  - lk=0: go to WAIT_LOCK; not a fault.
  - Otherwise cnt++. When cnt == LOCK_WAIT-1, go to TX_UP with cnt = 0. SETTLE lasts exactly LOCK_WAIT cycles.
- TX_UP: cnt++. When cnt == TX_LEAD-1, go to TIMING_UP; reset cnt and tmo.
- TIMING_UP: on the first vs_edge, go to BLANK with frm = 0 and tmo = 0.
- BLANK:
  - Each vs_edge does frm++ and tmo = 0.
  - On the vs_edge where frm == BLANK_FRAMES-1, go to RUN. pic_en therefore rises exactly on a frame boundary.
- RUN: stays until a fault. tmo resets on every vs_edge.
- Fault conditions, checked in TX_UP..RUN (fault has priority over all other transitions that cycle):
  - lk=0 (checked in TX_UP..RUN).
  - tmo == VS_TIMEOUT-1 with no vs_edge that cycle (checked in TIMING_UP, BLANK, RUN only).
- Fault action: go to FAULT; fault_cnt++ saturating at 255; cnt = 0. Outputs drop on the next edge.
- FAULT: cnt++. When cnt == FAULT_HOLD-1, go to WAIT_LOCK. Lock state is ignored while in FAULT.
- tmo counts 0..VS_TIMEOUT-1 and is 24 bits wide; it never wraps because the fault fires first.
- Counter widths:
  - cnt: 16 bits, shared by SETTLE, TX_UP and FAULT.
  - frm: 4 bits.
- Simultaneous events:
  - vs_edge together with tmo terminal: no fault; the edge wins.
  - lk falling together with vs_edge in BLANK: fault wins.

Test Plan (bench params: LOCK_WAIT=20, TX_LEAD=4, BLANK_FRAMES=2, VS_TIMEOUT=1000, FAULT_HOLD=8; vsync period 200 cycles):
- Nominal bring-up:
  - Stimulus: rstn high, pll_locked rises at cycle 10.
  - Response: SETTLE entered at edge 12; tx_rstn=1 at edge 32; timing_rstn=1 at edge 36; BLANK at the first vs edge; pic_en=1 exactly at the 3rd vs edge, not before.
- Lock glitch in SETTLE:
  - Stimulus: pll_locked drops for 3 cycles at SETTLE cnt=10.
  - Response: returns to WAIT_LOCK; fault_cnt stays 0; SETTLE restarts from 0 and takes the full 20 cycles after relock.
- Lock loss in RUN:
  - Stimulus: drop pll_locked.
  - Response: within 3 edges tx_rstn=0, timing_rstn=0, pic_en=0, state=FAULT, fault_cnt=1; WAIT_LOCK 8 cycles later; full re-bring-up once lock returns.
- Vsync timeout:
  - Stimulus: hold vs_in inactive in RUN.
  - Response: FAULT exactly 1000 cycles after the last vs edge; fault_cnt increments.
  - Stimulus: vs edge on the terminal tmo cycle.
  - Response: no fault.
- Saturation and reset:
  - Stimulus: force 260 faults.
  - Response: fault_cnt = 255.
  - Stimulus: assert rstn=0 for 1 cycle in BLANK.
  - Response: all outputs 0, state_o = 0, fault_cnt = 0 on the next edge.

Source files
------------

// File: rtl/video_bringup_ctrl_if.sv
// Board-side signal bundle for the HDMI picture-path bring-up sequencer.
//   pll_locked  : raw PLL lock (lock1 & lock2), asynchronous to pix_clk
//   vs_in       : vsync from the timing generator, pix_clk domain
//   tx_rstn     : active-low reset for the DVI transmitter
//   timing_rstn : active-low reset for the sync generator and video source
//   pic_en      : 1 = pass picture, 0 = force black
//   state_o     : current sequencer state code
//   fault_cnt   : saturating count of faults taken
// master = the sequencer, slave = the board / video path it controls.
interface video_bringup_ctrl_if;
   logic       pll_locked;
   logic       vs_in;
   logic       tx_rstn;
   logic       timing_rstn;
   logic       pic_en;
   logic [2:0] state_o;
   logic [7:0] fault_cnt;

   modport master (
      input  pll_locked, vs_in,
      output tx_rstn, timing_rstn, pic_en, state_o, fault_cnt
   );

   modport slave (
      output pll_locked, vs_in,
      input  tx_rstn, timing_rstn, pic_en, state_o, fault_cnt
   );
endinterface

// File: rtl/video_bringup_ctrl.sv
// Power-up and recovery sequencer for the HDMI picture path.
// Waits for a stable PLL lock, releases the DVI transmitter reset, then the
// timing generator reset, blanks BLANK_FRAMES frames and enables the picture.
// Lock loss or a missing vsync tears the path down, bumps fault_cnt and the
// sequence restarts by itself after FAULT_HOLD cycles.
// Ports:
//   pix_clk : pixel clock, the only clock
//   rstn    : synchronous active-low reset
//   bus     : video_bringup_ctrl_if.master (lock/vsync in, resets/enable/status out)
module video_bringup_ctrl #(
   parameter logic [15:0] LOCK_WAIT    = 16'd10000,
   parameter logic [7:0]  TX_LEAD      = 8'd16,
   parameter logic [3:0]  BLANK_FRAMES = 4'd2,
   parameter logic [23:0] VS_TIMEOUT   = 24'd4000000,
   parameter logic [7:0]  FAULT_HOLD   = 8'd32,
   parameter logic        VS_POL       = 1'b1
) (
   input logic                  pix_clk,
   input logic                  rstn,
   video_bringup_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_WAIT_LOCK = 3'd0,
      S_SETTLE    = 3'd1,
      S_TX_UP     = 3'd2,
      S_TIMING_UP = 3'd3,
      S_BLANK     = 3'd4,
      S_RUN       = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   // Terminal counts, precomputed at full counter width.
   localparam logic [15:0] SETTLE_LAST = LOCK_WAIT - 16'd1;
   localparam logic [15:0] TX_LAST     = {8'd0, TX_LEAD} - 16'd1;
   localparam logic [15:0] HOLD_LAST   = {8'd0, FAULT_HOLD} - 16'd1;
   localparam logic [23:0] TMO_LAST    = VS_TIMEOUT - 24'd1;
   localparam logic [3:0]  FRM_LAST    = BLANK_FRAMES - 4'd1;

   state_t      state_reg;
   logic        lk_meta_reg;
   logic        lk_reg;
   logic        vs_d_reg;
   logic [15:0] cnt_reg;
   logic [23:0] tmo_reg;
   logic [3:0]  frm_reg;
   logic [7:0]  fault_cnt_reg;
   logic [2:0]  out_reg;          // {tx_rstn, timing_rstn, pic_en}

   logic vs_edge;
   logic fault_now;

   // Output pattern belonging to a state. Loaded together with the state
   // register so the outputs are registered yet track the state with no lag.
   function automatic logic [2:0] moore_out(input state_t s);
      logic tx;
      logic tim;
      logic pic;
      tx  = (s inside {S_TX_UP, S_TIMING_UP, S_BLANK, S_RUN});
      tim = (s inside {S_TIMING_UP, S_BLANK, S_RUN});
      pic = (s == S_RUN);
      return {tx, tim, pic};
   endfunction

   assign vs_edge = (bus.vs_in == VS_POL) && (vs_d_reg != VS_POL);

   // Lock loss is watched from TX_UP on; the vsync watchdog only once the
   // timing generator is running. A vsync edge on the terminal cycle rescues.
   always_comb begin
      fault_now = 1'b0;
      if (state_reg inside {S_TX_UP, S_TIMING_UP, S_BLANK, S_RUN}) begin
         if (!lk_reg)
            fault_now = 1'b1;
         else if ((state_reg != S_TX_UP) && (tmo_reg == TMO_LAST) && !vs_edge)
            fault_now = 1'b1;
      end
   end

   always_ff @(posedge pix_clk) begin
      if (!rstn) begin
         state_reg     <= S_WAIT_LOCK;
         lk_meta_reg   <= 1'b0;
         lk_reg        <= 1'b0;
         vs_d_reg      <= ~VS_POL;
         cnt_reg       <= '0;
         tmo_reg       <= '0;
         frm_reg       <= '0;
         fault_cnt_reg <= '0;
         out_reg       <= '0;
      end else begin
         lk_meta_reg <= bus.pll_locked;
         lk_reg      <= lk_meta_reg;
         vs_d_reg    <= bus.vs_in;

         if (fault_now) begin
            state_reg <= S_FAULT;
            out_reg   <= moore_out(S_FAULT);
            cnt_reg   <= '0;
            if (fault_cnt_reg != 8'hFF)
               fault_cnt_reg <= fault_cnt_reg + 8'd1;
         end else begin
            case (state_reg)
               S_WAIT_LOCK: begin
                  if (lk_reg) begin
                     state_reg <= S_SETTLE;
                     out_reg   <= moore_out(S_SETTLE);
                     cnt_reg   <= '0;
                  end
               end
               S_SETTLE: begin
                  if (!lk_reg) begin
                     // Lock bounced before bring-up: just start over, no fault.
                     state_reg <= S_WAIT_LOCK;
                     out_reg   <= moore_out(S_WAIT_LOCK);
                  end else if (cnt_reg == SETTLE_LAST) begin
                     state_reg <= S_TX_UP;
                     out_reg   <= moore_out(S_TX_UP);
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 16'd1;
                  end
               end
               S_TX_UP: begin
                  if (cnt_reg == TX_LAST) begin
                     state_reg <= S_TIMING_UP;
                     out_reg   <= moore_out(S_TIMING_UP);
                     cnt_reg   <= '0;
                     tmo_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 16'd1;
                  end
               end
               S_TIMING_UP: begin
                  if (vs_edge) begin
                     state_reg <= S_BLANK;
                     out_reg   <= moore_out(S_BLANK);
                     frm_reg   <= '0;
                     tmo_reg   <= '0;
                  end else begin
                     tmo_reg <= tmo_reg + 24'd1;
                  end
               end
               S_BLANK: begin
                  if (vs_edge) begin
                     tmo_reg <= '0;
                     if (frm_reg == FRM_LAST) begin
                        // Picture enable lands exactly on a frame boundary.
                        state_reg <= S_RUN;
                        out_reg   <= moore_out(S_RUN);
                     end else begin
                        frm_reg <= frm_reg + 4'd1;
                     end
                  end else begin
                     tmo_reg <= tmo_reg + 24'd1;
                  end
               end
               S_RUN: begin
                  if (vs_edge)
                     tmo_reg <= '0;
                  else
                     tmo_reg <= tmo_reg + 24'd1;
               end
               S_FAULT: begin
                  // Lock is deliberately ignored here; the hold always runs out.
                  if (cnt_reg == HOLD_LAST) begin
                     state_reg <= S_WAIT_LOCK;
                     out_reg   <= moore_out(S_WAIT_LOCK);
                  end else begin
                     cnt_reg <= cnt_reg + 16'd1;
                  end
               end
               default: begin
                  state_reg <= S_WAIT_LOCK;
                  out_reg   <= moore_out(S_WAIT_LOCK);
               end
            endcase
         end
      end
   end

   assign bus.tx_rstn     = out_reg[2];
   assign bus.timing_rstn = out_reg[1];
   assign bus.pic_en      = out_reg[0];
   assign bus.state_o     = state_reg;
   assign bus.fault_cnt   = fault_cnt_reg;

endmodule

// File: tb/tb_video_bringup_ctrl.sv
// Testbench for video_bringup_ctrl: directed stimulus with literal expectations
// plus a timestamp-based reference model compared against the DUT every cycle.
module tb_video_bringup_ctrl;

   localparam int   LW  = 20;
   localparam int   TL  = 4;
   localparam int   BF  = 2;
   localparam int   VT  = 1000;
   localparam int   FH  = 8;
   localparam logic POL = 1'b1;

   logic pix_clk = 1'b0;
   logic rstn    = 1'b0;
   logic pll     = 1'b0;
   logic vs      = 1'b0;

   video_bringup_ctrl_if bus ();

   assign bus.pll_locked = pll;
   assign bus.vs_in      = vs;

   video_bringup_ctrl #(
      .LOCK_WAIT    (16'd20),
      .TX_LEAD      (8'd4),
      .BLANK_FRAMES (4'd2),
      .VS_TIMEOUT   (24'd1000),
      .FAULT_HOLD   (8'd8),
      .VS_POL       (1'b1)
   ) dut (
      .pix_clk (pix_clk),
      .rstn    (rstn),
      .bus     (bus.master)
   );

   always #5 pix_clk = ~pix_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Phases use the published state codes; timing is tracked as absolute
   // edge timestamps rather than counters.
   int  cyc       = 0;
   int  m_ph      = 0;
   int  m_t0      = 0;     // edge at which the current timed phase began
   int  m_last    = 0;     // edge of last vsync edge (or watchdog start)
   int  m_frames  = 0;     // vsync edges seen since BLANK entry
   int  m_faults  = 0;
   bit  m_valid   = 0;
   bit  h_v1 = 0, h_v2 = 0;   // rstn&&pll sampled one / two edges ago
   bit  h_r1 = 0;             // rstn sampled one edge ago
   bit  h_vs1 = 0;            // vs_in sampled one edge ago

   logic [13:0] dut_vec;
   logic [13:0] exp_vec;
   assign dut_vec = {bus.state_o, bus.tx_rstn, bus.timing_rstn, bus.pic_en, bus.fault_cnt};

   task automatic model_step();
      bit lk, vd, edge_seen, fault;
      cyc++;
      // Lock seen by the FSM is the pin two edges back, zeroed by any reset since.
      lk = h_r1 && h_v2;
      vd = h_r1 ? h_vs1 : ~POL;
      edge_seen = (vs == POL) && (vd != POL);
      h_v2  = h_v1;
      h_v1  = rstn && pll;
      h_r1  = rstn;
      h_vs1 = vs;

      if (!rstn) begin
         m_ph = 0; m_faults = 0; m_valid = 1;
      end else begin
         fault = 0;
         if (m_ph >= 2 && m_ph <= 5) begin
            if (!lk) fault = 1;
            else if (m_ph >= 3 && !edge_seen && (cyc - m_last) == VT) fault = 1;
         end
         if (fault) begin
            m_ph = 6; m_t0 = cyc;
            m_faults = (m_faults < 255) ? m_faults + 1 : 255;
         end else begin
            case (m_ph)
               0: if (lk) begin m_ph = 1; m_t0 = cyc; end
               1: begin
                  if (!lk) m_ph = 0;
                  else if (cyc - m_t0 == LW) begin m_ph = 2; m_t0 = cyc; end
               end
               2: if (cyc - m_t0 == TL) begin m_ph = 3; m_last = cyc; end
               3: if (edge_seen) begin m_ph = 4; m_frames = 0; m_last = cyc; end
               4: if (edge_seen) begin
                  m_frames++; m_last = cyc;
                  if (m_frames == BF) m_ph = 5;
               end
               5: if (edge_seen) m_last = cyc;
               6: if (cyc - m_t0 == FH) m_ph = 0;
               default: m_ph = 0;
            endcase
         end
      end
      exp_vec = {3'(m_ph), (m_ph >= 2 && m_ph <= 5), (m_ph >= 3 && m_ph <= 5),
                 (m_ph == 5), 8'(m_faults)};
   endtask

   initial begin
      forever begin
         @(negedge pix_clk);
         model_step();
         if (m_valid) chk($sformatf("cycle%0d", cyc), int'(dut_vec), int'(exp_vec));
      end
   end

   // ---------------- stimulus ----------------
   bit vs_auto = 0;
   int vs_ph   = 0;

   task automatic cyc1();
      @(negedge pix_clk);
      #1;
      if (vs_auto) begin
         vs_ph = (vs_ph == 199) ? 0 : vs_ph + 1;
         vs    = (vs_ph < 10);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) cyc1();
   endtask

   task automatic vs_pulse();
      vs = 1'b1;
      cyc1();
      vs = 1'b0;
   endtask

   task automatic wait_state(input int s, input int max, input string name);
      int k = 0;
      while (int'(bus.state_o) != s && k < max) begin
         cyc1();
         k++;
      end
      chk(name, int'(bus.state_o), s);
   endtask

   task automatic start_auto_vs();
      vs_ph   = 199;
      vs_auto = 1;
   endtask

   initial begin
      adv(3);
      chk("rst_state", int'(bus.state_o), 0);
      chk("rst_tx", int'(bus.tx_rstn), 0);
      chk("rst_timing", int'(bus.timing_rstn), 0);
      chk("rst_pic", int'(bus.pic_en), 0);
      chk("rst_fcnt", int'(bus.fault_cnt), 0);

      // Nominal bring-up: rstn released before edge 1, lock sampled at edge 10.
      rstn = 1'b1;
      adv(9);
      pll = 1'b1;
      adv(2);  chk("settle_edge11", int'(bus.state_o), 0);
      adv(1);  chk("settle_edge12", int'(bus.state_o), 1);
      adv(19); chk("tx_edge31", int'(bus.tx_rstn), 0);
      adv(1);  chk("tx_edge32", int'(bus.tx_rstn), 1);
               chk("state_edge32", int'(bus.state_o), 2);
      adv(3);  chk("tim_edge35", int'(bus.timing_rstn), 0);
      adv(1);  chk("tim_edge36", int'(bus.timing_rstn), 1);
               chk("state_edge36", int'(bus.state_o), 3);
      adv(20);
      vs_pulse(); chk("blank_1st_vs", int'(bus.state_o), 4);
                  chk("pic_1st_vs", int'(bus.pic_en), 0);
      adv(199);
      vs_pulse(); chk("blank_2nd_vs", int'(bus.state_o), 4);
      adv(199);   chk("pic_before_3rd", int'(bus.pic_en), 0);
      vs_pulse(); chk("pic_3rd_vs", int'(bus.pic_en), 1);
                  chk("run_3rd_vs", int'(bus.state_o), 5);

      // Vsync timeout: no further edge after the 3rd one.
      adv(999); chk("tmo_edge999", int'(bus.state_o), 5);
      adv(1);   chk("tmo_edge1000", int'(bus.state_o), 6);
                chk("tmo_fcnt", int'(bus.fault_cnt), 1);

      wait_state(3, 100, "rebringup_timing");
      start_auto_vs();
      wait_state(5, 1000, "rebringup_run");

      // Vsync edge on the terminal watchdog cycle must not fault.
      vs_auto = 0; vs = 1'b0;
      cyc1();
      vs_pulse();
      adv(999); chk("term_before", int'(bus.state_o), 5);
      vs_pulse(); chk("term_edge_no_fault", int'(bus.state_o), 5);
                  chk("term_fcnt", int'(bus.fault_cnt), 1);
      adv(999); chk("tmo2_edge999", int'(bus.state_o), 5);
      adv(1);   chk("tmo2_edge1000", int'(bus.state_o), 6);
                chk("tmo2_fcnt", int'(bus.fault_cnt), 2);

      wait_state(3, 100, "rebringup2_timing");
      start_auto_vs();
      wait_state(5, 1000, "rebringup2_run");

      // Lock loss in RUN.
      pll = 1'b0;
      adv(2); chk("loss_edge2", int'(bus.state_o), 5);
      adv(1); chk("loss_state", int'(bus.state_o), 6);
              chk("loss_tx", int'(bus.tx_rstn), 0);
              chk("loss_timing", int'(bus.timing_rstn), 0);
              chk("loss_pic", int'(bus.pic_en), 0);
              chk("loss_fcnt", int'(bus.fault_cnt), 3);
      adv(7); chk("hold_edge7", int'(bus.state_o), 6);
      adv(1); chk("hold_edge8", int'(bus.state_o), 0);

      // Relock, then a 3-cycle glitch at SETTLE cnt=10.
      pll = 1'b1;
      adv(3);  chk("glitch_settle", int'(bus.state_o), 1);
      adv(10);
      pll = 1'b0;
      adv(3);  chk("glitch_to_wait", int'(bus.state_o), 0);
               chk("glitch_fcnt", int'(bus.fault_cnt), 3);
      pll = 1'b1;
      adv(3);  chk("relock_settle", int'(bus.state_o), 1);
      adv(19); chk("relock_settle_end", int'(bus.state_o), 1);
      adv(1);  chk("relock_tx_up", int'(bus.state_o), 2);
      wait_state(5, 1000, "relock_run");

      // Saturation: 260 lock-loss faults.
      for (int i = 0; i < 260; i++) begin
         pll = 1'b0;
         wait_state(6, 10, "sat_fault");
         pll = 1'b1;
         wait_state(2, 60, "sat_tx_up");
      end
      chk("fcnt_saturated", int'(bus.fault_cnt), 255);

      // Reset for one cycle in BLANK.
      vs_auto = 0; vs = 1'b0;
      wait_state(3, 20, "pre_rst_timing");
      cyc1();
      vs_pulse(); chk("pre_rst_blank", int'(bus.state_o), 4);
      rstn = 1'b0;
      cyc1();
      chk("midrst_state", int'(bus.state_o), 0);
      chk("midrst_tx", int'(bus.tx_rstn), 0);
      chk("midrst_timing", int'(bus.timing_rstn), 0);
      chk("midrst_pic", int'(bus.pic_en), 0);
      chk("midrst_fcnt", int'(bus.fault_cnt), 0);
      rstn = 1'b1;
      start_auto_vs();
      wait_state(5, 1000, "post_rst_run");
      chk("post_rst_fcnt", int'(bus.fault_cnt), 0);

      adv(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

endmodule
